// File: rtl/dap_pkg.sv
// Shared definitions for the CMSIS-DAP command workers: status codes,
// worker state encoding and timing constants.
package dap_pkg;

   localparam logic [7:0]  DAP_OK    = 8'h00;
   localparam logic [7:0]  DAP_ERROR = 8'hFF;

   localparam int unsigned PRESC_W = 8;
   localparam int unsigned MS_W    = 10;
   localparam int unsigned MS_DIV  = 1000;

   typedef enum logic [1:0] {
      ST_RX   = 2'd0,
      ST_RUN  = 2'd1,
      ST_RESP = 2'd2,
      ST_DONE = 2'd3
   } dap_state_e;

endpackage

// File: rtl/dap_tick_gen.sv
// Microsecond prescaler with optional divide-by-1000 stage; emits one
// count_tick_c per delay unit while run is high.
module dap_tick_gen
   import dap_pkg::*;
#(
   parameter int unsigned CLOCK_FREQ_M = 60
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   input  logic unit_ms,
   output logic count_tick_c
);

   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [MS_W-1:0]    ms_q, ms_d;
   logic               us_tick_c;
   logic               ms_wrap_c;

   assign us_tick_c    = run && (presc_q == PRESC_W'(CLOCK_FREQ_M - 1));
   assign ms_wrap_c    = (ms_q == MS_W'(MS_DIV - 1));
   assign count_tick_c = us_tick_c && (!unit_ms || ms_wrap_c);

   // Next-state for the two dividers; clear wins over run.
   always_comb begin
      presc_d = presc_q;
      ms_d    = ms_q;
      if (clear) begin
         presc_d = '0;
         ms_d    = '0;
      end else if (run) begin
         presc_d = us_tick_c ? '0 : presc_q + PRESC_W'(1);
         if (unit_ms && us_tick_c) begin
            ms_d = ms_wrap_c ? '0 : ms_q + MS_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q <= '0;
         ms_q    <= '0;
      end else begin
         presc_q <= presc_d;
         ms_q    <= ms_d;
      end
   end

endmodule

// File: rtl/dap_delay_timer.sv
// CMSIS-DAP Delay command worker: collects a little-endian delay operand,
// waits in us or ms units, then writes a one-byte status to the response RAM.
module dap_delay_timer
   import dap_pkg::*;
#(
   parameter int unsigned CLOCK_FREQ_M = 60,
   parameter int unsigned DELAY_BYTES  = 2,
   parameter int unsigned ADDR_W       = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              start,
   input  logic              unit_ms,
   input  logic              abort,
   input  logic              dap_in_tvalid,
   output logic              dap_in_tready,
   input  logic [7:0]        dap_in_tdata,
   output logic [ADDR_W-1:0] ram_write_addr,
   output logic [7:0]        ram_write_data,
   output logic              ram_write_en,
   output logic [ADDR_W-1:0] packet_len,
   output logic              busy,
   output logic              done
);

   localparam int unsigned DW    = 8 * DELAY_BYTES;
   localparam int unsigned IDX_W = 2;

   dap_state_e        state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DW-1:0]     counter_q, counter_d;
   logic              unit_ms_q, unit_ms_d;
   logic              wr_en_q, wr_en_d;
   logic [7:0]        wr_data_q, wr_data_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              xfer_c;
   logic              last_byte_c;
   logic              tick_clear_c;
   logic              tick_run_c;
   logic              count_tick_c;

   assign dap_in_tready = enable && start && (state_q == ST_RX);
   assign xfer_c        = dap_in_tvalid && dap_in_tready;
   assign last_byte_c   = (idx_q == IDX_W'(DELAY_BYTES - 1));
   assign tick_run_c    = (state_q == ST_RUN);
   assign tick_clear_c  = !enable || !start || (state_q != ST_RUN);

   dap_tick_gen #(
      .CLOCK_FREQ_M (CLOCK_FREQ_M)
   ) u_tick_gen (
      .clk          (clk),
      .reset        (reset),
      .clear        (tick_clear_c),
      .run          (tick_run_c),
      .unit_ms      (unit_ms_q),
      .count_tick_c (count_tick_c)
   );

   // Worker FSM next-state; abort outranks byte transfers and count ticks.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      counter_d = counter_q;
      unit_ms_d = unit_ms_q;
      wr_en_d   = 1'b0;
      wr_data_d = wr_data_q;

      if (!enable) begin
         state_d   = ST_RX;
         idx_d     = '0;
         counter_d = '0;
         unit_ms_d = 1'b0;
         wr_data_d = DAP_OK;
      end else if (!start) begin
         state_d   = ST_RX;
         idx_d     = '0;
         counter_d = '0;
      end else begin
         case (state_q)
            ST_RX: begin
               if (abort) begin
                  state_d   = ST_RESP;
                  wr_en_d   = 1'b1;
                  wr_data_d = DAP_ERROR;
               end else if (xfer_c) begin
                  for (int unsigned k = 0; k < DELAY_BYTES; k++) begin
                     if (idx_q == IDX_W'(k)) counter_d[8*k +: 8] = dap_in_tdata;
                  end
                  if (last_byte_c) begin
                     idx_d     = '0;
                     unit_ms_d = unit_ms;
                     // A zero delay skips RUN so the counter never wraps.
                     if (counter_d == '0) begin
                        state_d   = ST_RESP;
                        wr_en_d   = 1'b1;
                        wr_data_d = DAP_OK;
                     end else begin
                        state_d = ST_RUN;
                     end
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end
            end
            ST_RUN: begin
               if (abort) begin
                  state_d   = ST_RESP;
                  wr_en_d   = 1'b1;
                  wr_data_d = DAP_ERROR;
               end else if (count_tick_c) begin
                  counter_d = counter_q - DW'(1);
                  if (counter_q == DW'(1)) begin
                     state_d   = ST_RESP;
                     wr_en_d   = 1'b1;
                     wr_data_d = DAP_OK;
                  end
               end
            end
            ST_RESP: state_d = ST_DONE;
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_RX;
         endcase
      end

      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_RX;
         idx_q     <= '0;
         counter_q <= '0;
         unit_ms_q <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_data_q <= DAP_OK;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         counter_q <= counter_d;
         unit_ms_q <= unit_ms_d;
         wr_en_q   <= wr_en_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign ram_write_addr = '0;
   assign packet_len     = ADDR_W'(1);
   assign ram_write_en   = wr_en_q;
   assign ram_write_data = wr_data_q;
   assign busy           = busy_q;
   assign done           = done_q;

endmodule
